// File: rtl/reg_file_sb_pkg.sv
// Shared register-file constants and ABI register names.
// Optional feature macro: REG_BYPASS_EN (write-through forwarding, see reg_file_sb).
package reg_names;

  localparam int DATA_WIDTH = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_SIZE   = $clog2(REG_COUNT);
  localparam int BUSY_CNT_W = $clog2(REG_COUNT + 1);

  typedef enum logic [REG_SIZE-1:0] {
    ZERO = 5'd0,  RA  = 5'd1,  SP  = 5'd2,  GP  = 5'd3,
    TP   = 5'd4,  T0  = 5'd5,  T1  = 5'd6,  T2  = 5'd7,
    S0   = 5'd8,  S1  = 5'd9,  A0  = 5'd10, A1  = 5'd11,
    A2   = 5'd12, A3  = 5'd13, A4  = 5'd14, A5  = 5'd15,
    A6   = 5'd16, A7  = 5'd17, S2  = 5'd18, S3  = 5'd19,
    S4   = 5'd20, S5  = 5'd21, S6  = 5'd22, S7  = 5'd23,
    S8   = 5'd24, S9  = 5'd25, S10 = 5'd26, S11 = 5'd27,
    T3   = 5'd28, T4  = 5'd29, T5  = 5'd30, T6  = 5'd31
  } regName_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/write-back side bus of the register file and scoreboard.
// The slave modport is the register file; master is the pipeline.
interface reg_file_sb_if
  import reg_names::*;
#(
  parameter int DATA_WIDTH = reg_names::DATA_WIDTH,
  parameter int REG_COUNT  = reg_names::REG_COUNT,
  parameter int READ_PORTS = 2
);
  localparam int REG_SIZE   = $clog2(REG_COUNT);
  localparam int BUSY_CNT_W = $clog2(REG_COUNT + 1);

  logic [READ_PORTS-1:0][REG_SIZE-1:0]   rd_addr;
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
  logic [READ_PORTS-1:0]                 rd_busy;
  logic                                  wr_en;
  logic [REG_SIZE-1:0]                   wr_addr;
  logic [DATA_WIDTH-1:0]                 wr_data;
  logic                                  iss_en;
  logic [REG_SIZE-1:0]                   iss_addr;
  logic                                  iss_ready;
  logic                                  flush;
  logic [BUSY_CNT_W-1:0]                 busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, iss_ready, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, iss_ready, busy_count
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: busy bits, issue acceptance, flush and busy count.
module reg_scoreboard
  import reg_names::*;
#(
  parameter int REG_COUNT = reg_names::REG_COUNT,
  parameter int ZERO_REG  = 1,
  localparam int REG_SIZE = $clog2(REG_COUNT),
  localparam int CNT_W    = $clog2(REG_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 wr_en,
  input  logic [REG_SIZE-1:0]  wr_addr,
  input  logic                 iss_en,
  input  logic [REG_SIZE-1:0]  iss_addr,
  input  logic                 flush,
  output logic                 iss_ready,
  output logic [REG_COUNT-1:0] busy,
  output logic [CNT_W-1:0]     busy_count
);

  logic wr_zero, iss_zero, iss_hit, accept, clr, inc, dec;

  always_comb begin
    wr_zero   = (ZERO_REG != 0) && (wr_addr == '0);
    iss_zero  = (ZERO_REG != 0) && (iss_addr == '0);
    iss_hit   = wr_en && (wr_addr == iss_addr);
    iss_ready = rstN && !flush && (!busy[iss_addr] || iss_hit);
    accept    = iss_en && iss_ready && !iss_zero;
    clr       = wr_en && !wr_zero;
    inc       = accept && !busy[iss_addr];
    // a same-register issue keeps the bit set, so the retiring write must not count down
    dec       = clr && busy[wr_addr] && !(accept && iss_hit);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy       <= '0;
      busy_count <= '0;
    end else if (flush) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (clr)    busy[wr_addr]  <= 1'b0;
      if (accept) busy[iss_addr] <= 1'b1;
      busy_count <= busy_count + CNT_W'(inc) - CNT_W'(dec);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with pending-write scoreboard for the pipelined core.
// Define REG_BYPASS_EN to forward the write-back value to same-cycle reads.
module reg_file_sb
  import reg_names::*;
#(
  parameter int DATA_WIDTH = reg_names::DATA_WIDTH,
  parameter int REG_COUNT  = reg_names::REG_COUNT,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic         clk,
  input  logic         rstN,
  reg_file_sb_if.slave bus
);

  localparam int REG_SIZE = $clog2(REG_COUNT);
  localparam int CNT_W    = $clog2(REG_COUNT + 1);

  logic [DATA_WIDTH-1:0] mem [REG_COUNT];
  logic [REG_COUNT-1:0]  busy;
  logic                  iss_ready;
  logic [CNT_W-1:0]      busy_count;
  logic                  wr_zero;

  reg_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .ZERO_REG  (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rstN       (rstN),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .iss_en     (bus.iss_en),
    .iss_addr   (bus.iss_addr),
    .flush      (bus.flush),
    .iss_ready  (iss_ready),
    .busy       (busy),
    .busy_count (busy_count)
  );

  assign bus.iss_ready  = iss_ready;
  assign bus.busy_count = busy_count;
  assign wr_zero        = (ZERO_REG != 0) && (bus.wr_addr == '0);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int r = 0; r < REG_COUNT; r++) mem[r] <= '0;
    end else if (bus.wr_en && !wr_zero) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    for (int i = 0; i < READ_PORTS; i++) begin
      logic [REG_SIZE-1:0] a;
      logic                a_zero;
      a              = bus.rd_addr[i];
      a_zero         = (ZERO_REG != 0) && (a == '0);
      bus.rd_data[i] = mem[a];
      bus.rd_busy[i] = busy[a];
`ifdef REG_BYPASS_EN
      if (bus.wr_en && (bus.wr_addr == a)) begin
        bus.rd_data[i] = bus.wr_data;
        bus.rd_busy[i] = 1'b0;
      end
`endif
      if (a_zero || !rstN) begin
        bus.rd_data[i] = '0;
        bus.rd_busy[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (honours REG_BYPASS_EN when defined).
module tb_reg_file_sb;
  import reg_names::*;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_WIDTH(32), .REG_COUNT(32), .READ_PORTS(2)) bus ();

  reg_file_sb #(
    .DATA_WIDTH (32),
    .REG_COUNT  (32),
    .READ_PORTS (2),
    .ZERO_REG   (1)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en  = 1'b0;
    bus.iss_en = 1'b0;
    bus.flush  = 1'b0;
  endtask

  initial begin
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.flush    = 1'b0;

    // reset state
    #2;
    check("rst_busy_count", 64'(bus.busy_count), 64'd0);
    check("rst_iss_ready",  64'(bus.iss_ready),  64'd0);
    check("rst_rd_data0",   64'(bus.rd_data[0]), 64'd0);
    check("rst_rd_busy",    64'(bus.rd_busy),    64'd0);
    #10 rstN = 1'b1;
    tick();

    // write a0
    bus.rd_addr[0] = A0;
    bus.wr_en = 1'b1; bus.wr_addr = A0; bus.wr_data = 32'hDEADBEEF;
    #1;
`ifdef REG_BYPASS_EN
    check("a0_same_cycle", 64'(bus.rd_data[0]), 64'hDEADBEEF);
`else
    check("a0_same_cycle", 64'(bus.rd_data[0]), 64'h0);
`endif
    tick(); idle();
    check("a0_data", 64'(bus.rd_data[0]), 64'hDEADBEEF);
    check("a0_busy", 64'(bus.rd_busy[0]), 64'd0);

    // write to x0 ignored
    bus.wr_en = 1'b1; bus.wr_addr = ZERO; bus.wr_data = 32'd5;
    bus.rd_addr[0] = ZERO;
    tick(); idle();
    check("x0_reads_zero", 64'(bus.rd_data[0]), 64'd0);

    // issue t0, WAW stall, write-back clears
    bus.iss_en = 1'b1; bus.iss_addr = T0;
    #1;
    check("t0_iss_ready", 64'(bus.iss_ready), 64'd1);
    tick(); idle();
    bus.rd_addr[0] = T0;
    #1;
    check("t0_busy",        64'(bus.rd_busy[0]),  64'd1);
    check("t0_busy_count",  64'(bus.busy_count),  64'd1);
    check("t0_waw_stall",   64'(bus.iss_ready),   64'd0);
    bus.wr_en = 1'b1; bus.wr_addr = T0; bus.wr_data = 32'h55;
    #1;
    check("t0_retire_ready", 64'(bus.iss_ready), 64'd1);
    tick(); idle();
    check("t0_busy_clr",    64'(bus.rd_busy[0]),  64'd0);
    check("t0_count_zero",  64'(bus.busy_count),  64'd0);
    check("t0_data",        64'(bus.rd_data[0]),  64'h55);

    // same-cycle write-back and issue to x7: issue wins
    bus.iss_en = 1'b1; bus.iss_addr = T2;
    tick(); idle();
    check("x7_count1", 64'(bus.busy_count), 64'd1);
    bus.wr_en = 1'b1; bus.wr_addr = T2; bus.wr_data = 32'h77;
    bus.iss_en = 1'b1; bus.iss_addr = T2;
    #1;
    check("x7_wr_iss_ready", 64'(bus.iss_ready), 64'd1);
    tick(); idle();
    bus.rd_addr[0] = T2;
    #1;
    check("x7_still_busy", 64'(bus.rd_busy[0]), 64'd1);
    check("x7_new_data",   64'(bus.rd_data[0]), 64'h77);
    check("x7_count_same", 64'(bus.busy_count), 64'd1);

    // fill the scoreboard (x7 already busy, so still 31 total)
    for (int r = 1; r < 32; r++) begin
      bus.iss_en = 1'b1; bus.iss_addr = 5'(r);
      tick();
    end
    idle();
    bus.rd_addr[1] = T6;
    #1;
    check("full_count", 64'(bus.busy_count), 64'd31);
    check("x31_busy",   64'(bus.rd_busy[1]), 64'd1);
    bus.iss_addr = S4;
    #1;
    check("full_stall", 64'(bus.iss_ready), 64'd0);

    // flush with issue to x0 and write to x3
    bus.flush = 1'b1;
    bus.iss_en = 1'b1; bus.iss_addr = ZERO;
    bus.wr_en = 1'b1; bus.wr_addr = GP; bus.wr_data = 32'h1;
    #1;
    check("flush_iss_ready", 64'(bus.iss_ready), 64'd0);
    tick(); idle();
    check("flush_count", 64'(bus.busy_count), 64'd0);
    begin
      logic [31:0] any_busy;
      any_busy = '0;
      for (int r = 0; r < 32; r++) begin
        bus.rd_addr[0] = 5'(r);
        #1;
        any_busy[r] = bus.rd_busy[0];
      end
      check("flush_all_clear", 64'(any_busy), 64'd0);
    end
    bus.rd_addr[0] = GP;
    #1;
    check("x3_data", 64'(bus.rd_data[0]), 64'h1);

    // bypass behaviour on port 1
    bus.rd_addr[1] = A2;
    bus.wr_en = 1'b1; bus.wr_addr = A2; bus.wr_data = 32'hA5A5A5A5;
    #1;
`ifdef REG_BYPASS_EN
    check("x12_same_cycle", 64'(bus.rd_data[1]), 64'hA5A5A5A5);
`else
    check("x12_same_cycle", 64'(bus.rd_data[1]), 64'h0);
`endif
    tick(); idle();
    check("x12_next_cycle", 64'(bus.rd_data[1]), 64'hA5A5A5A5);

    // x0 never forwarded
    bus.rd_addr[0] = ZERO;
    bus.wr_en = 1'b1; bus.wr_addr = ZERO; bus.wr_data = 32'hFFFF_FFFF;
    #1;
    check("x0_no_forward", 64'(bus.rd_data[0]), 64'd0);
    bus.iss_addr = ZERO;
    bus.wr_en = 1'b0;
    #1;
    check("x0_iss_ready", 64'(bus.iss_ready), 64'd1);
    tick(); idle();

    // mid-operation asynchronous reset
    bus.wr_en = 1'b1; bus.wr_addr = TP; bus.wr_data = 32'h44;
    bus.iss_en = 1'b1; bus.iss_addr = S1;
    tick(); idle();
    bus.rd_addr[0] = TP;
    bus.rd_addr[1] = S1;
    #1;
    check("pre_rst_data",  64'(bus.rd_data[0]), 64'h44);
    check("pre_rst_count", 64'(bus.busy_count), 64'd1);
    #1 rstN = 1'b0;
    #1;
    check("arst_data",   64'(bus.rd_data[0]), 64'd0);
    check("arst_busy",   64'(bus.rd_busy[1]), 64'd0);
    check("arst_count",  64'(bus.busy_count), 64'd0);
    check("arst_ready",  64'(bus.iss_ready),  64'd0);
    #4 rstN = 1'b1;
    tick();
    check("post_rst_data",  64'(bus.rd_data[0]), 64'd0);
    check("post_rst_busy",  64'(bus.rd_busy[1]), 64'd0);
    check("post_rst_ready", 64'(bus.iss_ready),  64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised integer register file with a pending-write scoreboard for the pipelined RISC-V core. It holds REG_COUNT architectural registers of DATA_WIDTH bits and provides READ_PORTS combinational read ports plus one write-back port. A per-register busy bit is set at issue and cleared at write-back, so decode can detect RAW/WAW hazards. It sits between decode (read and issue side) and write-back.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- REG_COUNT, 32, number of architectural registers
- READ_PORTS, 2, number of independent read ports (1..4)
- ZERO_REG, 1, when 1, register 0 is hard-wired zero and never busy

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rstN  in  1  asynchronous active-low reset
- rd_addr  in  READ_PORTS×REG_SIZE  read addresses
- rd_data  out  READ_PORTS×DATA_WIDTH  read data
- rd_busy  out  READ_PORTS  addressed register has an outstanding write
- wr_en  in  1  write-back valid
- wr_addr  in  REG_SIZE  write-back destination
- wr_data  in  DATA_WIDTH  write-back value
- iss_en  in  1  issue request that marks iss_addr busy
- iss_addr  in  REG_SIZE  destination of the issuing instruction
- iss_ready  out  1  issue accepted this cycle
- flush  in  1  clear the whole scoreboard (pipeline squash)
- busy_count  out  $clog2(REG_COUNT+1)  number of busy registers

## Operation
- Reset (asynchronous, rstN=0): all registers = 0, all busy bits = 0, busy_count = 0. Outputs while in reset: rd_data = 0, rd_busy = 0, iss_ready = 0.
- Write: when wr_en=1, wr_data is stored at wr_addr and busy[wr_addr] is cleared. If ZERO_REG=1 and wr_addr=0, the write is ignored.
- Read: rd_data[i] = reg[rd_addr[i]] and rd_busy[i] = busy[rd_addr[i]]. Register 0 reads 0 and not-busy when ZERO_REG=1.
- Issue: iss_ready = !flush && (!busy[iss_addr] || (wr_en && wr_addr==iss_addr)). Issue stalls on WAW unless the write-back retires that register in the same cycle.
  - When iss_en && iss_ready: busy[iss_addr] is set.
  - Issue to register 0 with ZERO_REG=1 is always ready and has no effect.
- Simultaneous write-back and accepted issue to the same register: the issue wins, so the busy bit stays 1 and busy_count is unchanged.
- Flush: all busy bits are cleared and busy_count goes to 0 at the edge. A write in the same cycle still commits its data. An issue in the same cycle is discarded.
- busy_count: incremented by 1 on an accepted issue that sets a clear bit, decremented by 1 on a write that clears a set bit. The net change per cycle is in {-1, 0, +1}. It never wraps, because count ≤ REG_COUNT holds by construction.
- A write to a non-busy register is legal: the data commits and the count does not change.

## Timing
- Reads are combinational from rd_addr, with zero latency.
- A write is visible to reads in the cycle after its edge; with REG_BYPASS_EN it is visible in the same cycle.
- A busy set or clear is visible on rd_busy and iss_ready in the cycle after the edge.
- iss_ready is combinational from iss_addr, wr_en, wr_addr and flush. iss_en has no effect on iss_ready.
- Deasserting rstN in the middle of operation immediately zeroes all state. Release is synchronised by the system reset, not by this block.

## Configuration
- REG_BYPASS_EN defined: when wr_en && wr_addr==rd_addr[i] (and the address is non-zero if ZERO_REG=1):
  - rd_data[i] = wr_data
  - rd_busy[i] = 0
  - This gives write-through forwarding for the write-back stage.
- Not defined: reads return the stored value and the current busy bit only. Consumers stall one extra cycle after a write-back.

## Structure
- The shared package reg_names holds:
  - DATA_WIDTH, REG_COUNT and REG_SIZE
  - the regName_t enum, used by the bench for address literals
  - a new constant BUSY_CNT_W = $clog2(REG_COUNT+1)
- One sub-module, reg_scoreboard, holds the busy-bit vector, the iss_ready logic, flush and busy_count. The top level holds the storage array and read muxes/bypass.

## Test plan
- Reset, then write a0 (x10)=32'hDEADBEEF -> the next cycle a read of x10 returns 32'hDEADBEEF and rd_busy=0. A write of 5 to x0 -> x0 reads 0.
- Issue t0 (x5) -> the next cycle rd_busy=1 and busy_count=1. A second issue to x5 -> iss_ready=0. Write-back to x5 -> busy clears and busy_count=0.
- Same cycle: busy x7 written back and issued -> iss_ready=1; afterwards x7 stays busy with the new data and busy_count is unchanged.
- Issue x1..x31 on consecutive cycles -> busy_count=31. Assert flush together with an issue to x0 and a write of 32'h1 to x3 -> busy_count=0, all rd_busy=0, x3 reads 1.
- With REG_BYPASS_EN: write 32'hA5A5A5A5 to x12 while port 1 reads x12 -> rd_data[1]=32'hA5A5A5A5 in the same cycle. Without the macro, the old value is returned that cycle.
- Pull rstN low for half a cycle after several writes and issues -> all registers read 0, busy_count=0 and iss_ready=0 immediately.
